// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared FSM state encoding, requester ids and byte-enable constants
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam logic [3:0] WREN_NONE = 4'b0000;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester (IF, D) and RAM signals of the memory port arbiter
//   slave  : arbiter view (takes requests and mem_rdata, drives grants, responses, RAM strobes, busy)
//   master : environment view (fetch unit, load/store unit and RAM model)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic [3:0]        d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic [3:0]        mem_wren;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_wren, mem_addr, mem_wdata, busy
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_wren, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational winner select between fetch (IF) and load/store (D)
//   in : if_req, d_req, starve_cnt (default) or last_own (MEM_ARB_ROUND_ROBIN_EN)
//   out: any_req (someone is asking), own (winning requester id)
//   MEM_ARB_ROUND_ROBIN_EN: alternate on ties; otherwise D priority with IF starvation guard
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W = $clog2(STARVE_MAX + 1)
) (
  input  logic             if_req,
  input  logic             d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic             last_own,
`else
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  output logic             any_req,
  output logic             own
);
  always_comb begin
    any_req = if_req | d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    own = (if_req && d_req) ? ~last_own : (d_req ? OWN_D : OWN_IF);
`else
    own = (d_req && !(if_req && starve_cnt >= CNT_W'(STARVE_MAX))) ? OWN_D : OWN_IF;
`endif
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF and D accesses onto one single-ported RAM, one access in flight
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (requests, grants, responses, RAM port, busy)
//   MEM_ARB_ROUND_ROBIN_EN: strict alternation on ties instead of D priority + starvation guard
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  state_t     state;
  logic       owner;
  logic       is_store;
  logic [3:0] lat_cnt;
  logic       any_req;
  logic       pick_own;
  logic       gnt;
  logic       if_gnt;
  logic       d_gnt;
  logic       unused_addr_lsbs;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_own;
  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_req(bus.if_req), .d_req(bus.d_req), .last_own(last_own),
    .any_req(any_req), .own(pick_own)
  );
  // Resets to IF so that D takes the first tie
  always_ff @(posedge clk)
    if (rst) last_own <= OWN_IF;
    else if (gnt) last_own <= pick_own;
`else
  logic [CNT_W-1:0] starve_cnt;
  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_req(bus.if_req), .d_req(bus.d_req), .starve_cnt(starve_cnt),
    .any_req(any_req), .own(pick_own)
  );
  // Counts D grants taken while IF waits; saturates at the limit until IF is served
  always_ff @(posedge clk)
    if (rst || !bus.if_req || if_gnt) starve_cnt <= '0;
    else if (d_gnt && starve_cnt != CNT_W'(STARVE_MAX)) starve_cnt <= starve_cnt + CNT_W'(1);
`endif
  // Grants are only possible from IDLE and never while reset is applied
  always_comb begin
    gnt = !rst && state == IDLE && any_req;
    if_gnt = gnt && pick_own == OWN_IF;
    d_gnt = gnt && pick_own == OWN_D;
    bus.if_gnt = if_gnt;
    bus.d_gnt = d_gnt;
    bus.mem_en = gnt;
    bus.mem_wren = d_gnt ? bus.d_we : WREN_NONE;
    bus.mem_addr = !gnt ? '0 : (d_gnt ? bus.d_addr[ADDR_W-1:2] : bus.if_addr[ADDR_W-1:2]);
    bus.mem_wdata = d_gnt ? bus.d_wdata : '0;
    bus.busy = state != IDLE;
    unused_addr_lsbs = ^{bus.if_addr[1:0], bus.d_addr[1:0]};
  end
  // The response registers load on the WAIT->RESP edge so rvalid is high during RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_IF;
      is_store <= 1'b0;
      lat_cnt <= '0;
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      case (state)
        IDLE: if (gnt) begin
          owner <= pick_own;
          is_store <= d_gnt && bus.d_we != WREN_NONE;
          lat_cnt <= 4'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: if (lat_cnt == '0) begin
          state <= RESP;
          if (owner == OWN_D) begin
            bus.d_rvalid <= 1'b1;
            bus.d_rdata <= is_store ? '0 : bus.mem_rdata;
          end else begin
            bus.if_rvalid <= 1'b1;
            bus.if_rdata <= bus.mem_rdata;
          end
        end else lat_cnt <= lat_cnt - 4'd1;
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench, vector table plus scoreboard and corner-case sequences
module tb_mem_port_arbiter;
  typedef struct {
    logic        is_d;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  typedef struct {
    logic        own;
    logic [31:0] data;
    int          due;
  } sb_t;
  logic clk = 0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  sb_t sb[$];
  logic glog[$];
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  logic [31:0] rd_a;
  logic [31:0] pb0, pb1, pb2;
  sb_t m_e;
  logic m_own;
  logic [7:0] m_w;
  logic [3:0] m_we;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();
  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  // RAM for the MEM_LAT=1 instance: byte-lane writes, registered read
  always @(posedge clk)
    if (bus_a.mem_en) begin
      for (int l = 0; l < 4; l++)
        if (bus_a.mem_wren[l]) ram[bus_a.mem_addr[7:0]][8*l +: 8] <= bus_a.mem_wdata[8*l +: 8];
      rd_a <= ram[bus_a.mem_addr[7:0]];
    end
  assign bus_a.mem_rdata = rd_a;
  // Read-only RAM for the MEM_LAT=3 instance: data appears exactly 3 cycles after mem_en
  always @(posedge clk) begin
    pb0 <= bus_b.mem_en ? (32'hC0DE0000 | {24'd0, bus_b.mem_addr[7:0]}) : 32'd0;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign bus_b.mem_rdata = pb2;
  // Scoreboard on the MEM_LAT=1 instance: push on grant, pop on rvalid
  always @(negedge clk) begin
    cyc++;
    if (rst) sb.delete();
    else begin
      chk("gnt onehot", {63'd0, bus_a.if_gnt & bus_a.d_gnt}, 64'd0);
      chk("rvalid onehot", {63'd0, bus_a.if_rvalid & bus_a.d_rvalid}, 64'd0);
      if (bus_a.if_gnt | bus_a.d_gnt) begin
        m_own = bus_a.d_gnt;
        m_w = m_own ? bus_a.d_addr[9:2] : bus_a.if_addr[9:2];
        m_we = m_own ? bus_a.d_we : 4'b0000;
        chk("mem_addr", {34'd0, bus_a.mem_addr}, {34'd0, m_own ? bus_a.d_addr[31:2] : bus_a.if_addr[31:2]});
        chk("mem_wren", {60'd0, bus_a.mem_wren}, {60'd0, m_we});
        if (m_we != 4'b0000) chk("mem_wdata", {32'd0, bus_a.mem_wdata}, {32'd0, bus_a.d_wdata});
        m_e.own = m_own;
        m_e.data = (m_we != 4'b0000) ? 32'd0 : ref_mem[m_w];
        m_e.due = cyc + 2;
        for (int l = 0; l < 4; l++)
          if (m_we[l]) ref_mem[m_w][8*l +: 8] = bus_a.d_wdata[8*l +: 8];
        sb.push_back(m_e);
        glog.push_back(m_own);
      end
      if (bus_a.if_rvalid | bus_a.d_rvalid) begin
        if (sb.size() == 0) chk("unexpected rvalid", 64'd1, 64'd0);
        else begin
          m_e = sb.pop_front();
          chk("rvalid owner", {63'd0, bus_a.d_rvalid}, {63'd0, m_e.own});
          chk("sb rdata", {32'd0, m_e.own ? bus_a.d_rdata : bus_a.if_rdata}, {32'd0, m_e.data});
          chk("rvalid cycle", 64'(cyc), 64'(m_e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        m_e = sb.pop_front();
        chk("missing rvalid", 64'd0, 64'd1);
      end
    end
  end
  task automatic run_vec(input vec_t v);
    int t;
    logic g;
    @(posedge clk); #1;
    if (v.is_d) begin
      bus_a.d_req = 1; bus_a.d_we = v.we; bus_a.d_addr = v.addr; bus_a.d_wdata = v.wdata;
    end else begin
      bus_a.if_req = 1; bus_a.if_addr = v.addr;
    end
    t = 0; g = 0;
    while (!g && t < 20) begin
      @(negedge clk); t++;
      g = v.is_d ? bus_a.d_gnt : bus_a.if_gnt;
    end
    chk("vec gnt wait", 64'(t), 64'd1);
    if (g) chk("vec mem_en", {63'd0, bus_a.mem_en}, 64'd1);
    @(posedge clk); #1;
    bus_a.if_req = 0; bus_a.d_req = 0;
    t = 0; g = 0;
    while (!g && t < 20) begin
      @(negedge clk); t++;
      g = v.is_d ? bus_a.d_rvalid : bus_a.if_rvalid;
    end
    chk("vec rvalid latency", 64'(t), 64'd2);
    chk("vec rdata", {32'd0, v.is_d ? bus_a.d_rdata : bus_a.if_rdata}, {32'd0, v.exp});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t vecs[8];
    logic exp_order[10];
    int g[$];
    int r[$];
    int t;
    vecs[0] = '{0, 4'b0000, 32'h40,  32'h0,        32'hC0DE0010};
    vecs[1] = '{1, 4'b0011, 32'h8,   32'hAABBCCDD, 32'h0};
    vecs[2] = '{1, 4'b0000, 32'h8,   32'h0,        32'hC0DECCDD};
    vecs[3] = '{0, 4'b0000, 32'h8,   32'h0,        32'hC0DECCDD};
    vecs[4] = '{1, 4'b1100, 32'hC,   32'h11223344, 32'h0};
    vecs[5] = '{1, 4'b0000, 32'hE,   32'h0,        32'h11220003};
    vecs[6] = '{0, 4'b0000, 32'h3FC, 32'h0,        32'hC0DE00FF};
    vecs[7] = '{1, 4'b0000, 32'h0,   32'h0,        32'hC0DE0000};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'hC0DE0000 | i;
      ref_mem[i] = 32'hC0DE0000 | i;
    end
    rst = 1;
    bus_a.if_req = 1; bus_a.if_addr = 32'h40; bus_a.d_req = 1; bus_a.d_we = 0;
    bus_a.d_addr = 0; bus_a.d_wdata = 0;
    bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_addr = 32'h14; bus_b.d_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset ctrl", {58'd0, bus_a.if_gnt, bus_a.d_gnt, bus_a.if_rvalid, bus_a.d_rvalid, bus_a.mem_en, bus_a.busy}, 64'd0);
    chk("reset rdata", {bus_a.if_rdata, bus_a.d_rdata}, 64'd0);
    chk("reset mem bus", {bus_a.mem_wren, bus_a.mem_addr, bus_a.mem_wdata[29:0]}, 64'd0);
    @(posedge clk); #1;
    bus_a.if_req = 0; bus_a.d_req = 0; rst = 0;
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    chk("non-owner if_rdata held", {32'd0, bus_a.if_rdata}, 64'hC0DE00FF);
    // Back-to-back loads on the MEM_LAT=3 instance
    @(posedge clk); #1;
    bus_b.d_req = 1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus_b.d_gnt) g.push_back(k);
      if (bus_b.d_rvalid) begin
        r.push_back(k);
        chk("lat3 rdata", {32'd0, bus_b.d_rdata}, 64'hC0DE0005);
      end
      chk("lat3 busy", {63'd0, bus_b.busy}, {63'd0, !bus_b.d_gnt});
    end
    @(posedge clk); #1;
    bus_b.d_req = 0;
    repeat (6) @(negedge clk);
    chk("lat3 grant count", 64'(g.size()), 64'd3);
    chk("lat3 rvalid count", 64'(r.size()), 64'd2);
    if (g.size() >= 3 && r.size() >= 2) begin
      chk("lat3 gap0", 64'(g[1] - g[0]), 64'd5);
      chk("lat3 gap1", 64'(g[2] - g[1]), 64'd5);
      chk("lat3 rv0", 64'(r[0] - g[0]), 64'd4);
      chk("lat3 rv1", 64'(r[1] - g[1]), 64'd4);
    end
    // D request withdrawn in the IDLE cycle where IF gets the port
    @(posedge clk); #1;
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus_a.d_gnt && t < 20);
    chk("t6 d_gnt", {63'd0, bus_a.d_gnt}, 64'd1);
    @(posedge clk); #1;
    bus_a.d_addr = 32'h4; bus_a.if_req = 1; bus_a.if_addr = 32'h20;
    @(negedge clk);
    chk("t6 no gnt in WAIT", {62'd0, bus_a.if_gnt, bus_a.d_gnt}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_a.d_req = 0;
    @(negedge clk);
    chk("t6 if wins after d drop", {62'd0, bus_a.if_gnt, bus_a.d_gnt}, 64'b10);
    @(posedge clk); #1;
    bus_a.if_req = 0;
    repeat (3) @(negedge clk);
    run_vec('{0, 4'b0000, 32'h24, 32'h0, 32'hC0DE0009});
    // Reset in WAIT abandons the access
    @(posedge clk); #1;
    bus_a.if_req = 1; bus_a.if_addr = 32'h80;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus_a.if_gnt && t < 20);
    chk("t5 if_gnt", {63'd0, bus_a.if_gnt}, 64'd1);
    @(posedge clk); #1;
    bus_a.if_req = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t5 ctrl after rst", {58'd0, bus_a.if_gnt, bus_a.d_gnt, bus_a.if_rvalid, bus_a.d_rvalid, bus_a.mem_en, bus_a.busy}, 64'd0);
    chk("t5 rdata after rst", {bus_a.if_rdata, bus_a.d_rdata}, 64'd0);
    chk("t5 mem bus after rst", {bus_a.mem_wren, bus_a.mem_addr, bus_a.mem_wdata[29:0]}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5 no rvalid", {62'd0, bus_a.if_rvalid, bus_a.d_rvalid}, 64'd0);
    end
    // Both requesters held high from a fresh reset: grant order
    glog.delete();
    @(posedge clk); #1;
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h10;
    bus_a.if_req = 1; bus_a.if_addr = 32'h20;
    t = 0;
    while (glog.size() < 10 && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    bus_a.d_req = 0; bus_a.if_req = 0;
    repeat (6) @(negedge clk);
    chk("order count", 64'(glog.size()), 64'd10);
    if (glog.size() >= 10)
      for (int i = 0; i < 10; i++) chk($sformatf("order[%0d]", i), {63'd0, glog[i]}, {63'd0, exp_order[i]});
    chk("sb drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
